// File: rtl/regfile_pkg.sv
// Shared processor constants for the datapath stages: default word/register-number
// widths and the hardwired-zero register number.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_dffe_word.sv
// One DATA_W-bit storage word: loads d on the rising edge when en is high,
// cleared asynchronously by an active-low clrn.
module dffe_word
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile.sv
// Two-read/one-write register file with hardwired-zero r0 and write-through
// bypass; storage words are dffe_word instances.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wrActive;

    assign regs[0] = '0;

    // Each enable is gated by we AND its own address match, so a bad we
    // can only ever touch the addressed word.
    for (genvar i = 1; i < DEPTH; i++) begin : g_word
        logic en;
        assign en = we & (wn == ADDR_W'(i));

        dffe_word #(.DATA_W(DATA_W)) u_word (
            .clk (clk),
            .clrn(clrn),
            .en  (en),
            .d   (d),
            .q   (regs[i])
        );
    end

    assign wrActive = clrn && we && (wn != ADDR_W'(REG_ZERO));

    // Bypass and storage reads are both forced to zero while clrn is low.
    always_comb begin
        qa = '0;
        qb = '0;
        if (clrn) begin
            if (wrActive && (rna == wn)) begin
                qa = d;
            end else begin
                qa = regs[rna];
            end
            if (wrActive && (rnb == wn)) begin
                qb = d;
            end else begin
                qb = regs[rnb];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes expected qa/qb per cycle,
// a negedge monitor pops and compares.
module tb_regfile;

    logic        clk;
    logic        clrn;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;

    typedef struct {
        string       name;
        logic [31:0] qa;
        logic [31:0] qb;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] mdl [32];

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .clrn(clrn),
        .we  (we),
        .wn  (wn),
        .d   (d),
        .rna (rna),
        .rnb (rnb),
        .qa  (qa),
        .qb  (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per checked cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput({e.name, "_qa"}, qa, e.qa);
            checkOutput({e.name, "_qb"}, qb, e.qb);
        end
    end

    task automatic applyStimulus(input logic w, input logic [4:0] n, input logic [31:0] dat,
                                 input logic [4:0] a, input logic [4:0] b);
        we  = w;
        wn  = n;
        d   = dat;
        rna = a;
        rnb = b;
    endtask

    task automatic pushExp(input string name, input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        e.name = name;
        e.qa   = ea;
        e.qb   = eb;
        expQ.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #3 clrn = 1'b0;
        step();

        // Reset held: writes and bypass suppressed
        applyStimulus(1'b1, 5'd5, 32'hFFFFFFFF, 5'd5, 5'd0);
        pushExp("rst_bypass", 32'h0, 32'h0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        pushExp("rst_hold", 32'h0, 32'h0);
        step();

        clrn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            pushExp($sformatf("sweep%0d", i), 32'h0, 32'h0);
            step();
        end

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd4, 5'd6);
        pushExp("wr_r5", 32'h0, 32'h0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        pushExp("rd_r5", 32'hDEADBEEF, 32'hDEADBEEF);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd6);
        pushExp("rd_r4r6", 32'h0, 32'h0);
        step();

        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
        pushExp("r0_wr", 32'h0, 32'hDEADBEEF);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        pushExp("r0_after", 32'h0, 32'h0);
        step();

        applyStimulus(1'b1, 5'd7, 32'h11111111, 5'd5, 5'd6);
        pushExp("wr_r7", 32'hDEADBEEF, 32'h0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        pushExp("r7_hold", 32'h11111111, 32'h0);
        step();
        applyStimulus(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
        pushExp("bypass", 32'h22222222, 32'h22222222);
        step();
        applyStimulus(1'b0, 5'd7, 32'h33333333, 5'd7, 5'd7);
        pushExp("we0_nobyp", 32'h22222222, 32'h22222222);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        pushExp("r7_stored", 32'h22222222, 32'hDEADBEEF);
        step();

        applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd5);
        pushExp("wr_r3", 32'hA5A5A5A5, 32'hDEADBEEF);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        pushExp("rd_r3", 32'hA5A5A5A5, 32'hA5A5A5A5);
        step();

        // Reset pulse between edges while a write to r3 is presented
        applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd7);
        #1 clrn = 1'b0;
        pushExp("midrst", 32'h0, 32'h0);
        @(negedge clk);
        #2 we = 1'b0;
        #1 clrn = 1'b1;
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        pushExp("post_rst", 32'h0, 32'h0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        pushExp("post_rst_r5", 32'h0, 32'h0);
        step();

        // Random regression against a reference array, from a fresh reset
        clrn = 1'b0;
        #1 clrn = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int c = 0; c < 10000; c++) begin
            logic        w;
            logic [4:0]  n, a, b;
            logic [31:0] dat, ea, eb;
            w   = ($urandom_range(0, 3) != 0);
            n   = 5'($urandom_range(0, 31));
            dat = $urandom;
            a   = 5'($urandom_range(0, 31));
            b   = ($urandom_range(0, 3) == 0) ? n : 5'($urandom_range(0, 31));
            ea  = (w && n != 5'd0 && a == n) ? dat : mdl[a];
            eb  = (w && n != 5'd0 && b == n) ? dat : mdl[b];
            applyStimulus(w, n, dat, a, b);
            pushExp("rand", ea, eb);
            @(posedge clk);
            if (w && n != 5'd0) mdl[n] = dat;
            #1;
        end

        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
